lsu_stage: RTL and testbench

Load/store stage that consumes the execute stage's result word (effective address) and store operand (rs2). Drives a req/gnt/rvalid data-memory port and formats store data and byte enables. Returns aligned, sign/zero-extended load data to writeback. Stalls the pipeline for the whole access.

---
 rtl/lsu_stage_pkg.sv | 30 +++
 rtl/lsu_align.sv | 70 +++++++
 rtl/lsu_stage.sv | 186 ++++++++++++++++++
 tb/tb_lsu_stage.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_stage_pkg.sv
// Shared definitions for the load/store stage: word width, memory access
// size encodings, the LSU state type and the misalignment predicate used
// when LSU_MISALIGN_TRAP_EN is defined.
package riscv_defines;

    localparam int WORD_WIDTH = 32;

    localparam logic [1:0] MEM_BYTE = 2'b00;
    localparam logic [1:0] MEM_HALF = 2'b01;
    localparam logic [1:0] MEM_WORD = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } lsu_state_t;

    // Halves need addr[0]=0; words (and the reserved size) need addr[1:0]=0.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
        logic mis;
        case (size)
            MEM_BYTE: mis = 1'b0;
            MEM_HALF: mis = off[0];
            default:  mis = (off != 2'b00);
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational data alignment for the LSU: byte-enable and replicated
// store-data generation, plus load-data extraction and sign/zero extension.
// Address bits that a size does not use are treated as zero.
module lsu_align
    import riscv_defines::*;
(
    input  logic [1:0]            addr_lo,
    input  logic [1:0]            size,
    input  logic                  load_unsigned,
    input  logic [WORD_WIDTH-1:0] store_data,
    input  logic [WORD_WIDTH-1:0] rdata,
    output logic [3:0]            be,
    output logic [WORD_WIDTH-1:0] wdata,
    output logic [WORD_WIDTH-1:0] load_data
);

    logic [1:0]            offset_s;
    logic [WORD_WIDTH-1:0] shifted_s;

    // Effective byte offset, byte enables and replicated store data per size.
    always_comb begin
        offset_s = 2'b00;
        be       = 4'b1111;
        wdata    = store_data;
        case (size)
            MEM_BYTE: begin
                offset_s = addr_lo;
                be       = 4'b0001 << addr_lo;
                wdata    = {4{store_data[7:0]}};
            end
            MEM_HALF: begin
                offset_s = {addr_lo[1], 1'b0};
                be       = 4'b0011 << {addr_lo[1], 1'b0};
                wdata    = {2{store_data[15:0]}};
            end
            default: begin
                offset_s = 2'b00;
                be       = 4'b1111;
                wdata    = store_data;
            end
        endcase
    end

    assign shifted_s = rdata >> {offset_s, 3'b000};

    // Pick the addressed byte/half from the read word and extend it.
    always_comb begin
        load_data = shifted_s;
        case (size)
            MEM_BYTE: begin
                if (load_unsigned) begin
                    load_data = {24'h000000, shifted_s[7:0]};
                end else begin
                    load_data = {{24{shifted_s[7]}}, shifted_s[7:0]};
                end
            end
            MEM_HALF: begin
                if (load_unsigned) begin
                    load_data = {16'h0000, shifted_s[15:0]};
                end else begin
                    load_data = {{16{shifted_s[15]}}, shifted_s[15:0]};
                end
            end
            default: begin
                load_data = shifted_s;
            end
        endcase
    end

endmodule

// File: rtl/lsu_stage.sv
// Load/store pipeline stage driving a req/gnt/rvalid data-memory port.
// One access at a time; the upstream pipeline is stalled until the response.
// Optional macro LSU_MISALIGN_TRAP_EN: misaligned halves/words are trapped
// (misaligned_o pulse) instead of being issued with low address bits ignored.
module lsu_stage
    import riscv_defines::*;
(
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [WORD_WIDTH-1:0] ex_data_i,
    input  logic [WORD_WIDTH-1:0] rdata2_store_i,
    input  logic                  load_en_i,
    input  logic                  store_en_i,
    input  logic [1:0]            mem_size_i,
    input  logic                  load_unsigned_i,
    output logic                  lsu_stall_o,
    output logic [WORD_WIDTH-1:0] wb_data_o,
    output logic                  wb_valid_o,
    output logic                  misaligned_o,
    output logic                  data_req_o,
    input  logic                  data_gnt_i,
    input  logic                  data_rvalid_i,
    output logic [WORD_WIDTH-1:0] data_addr_o,
    output logic                  data_we_o,
    output logic [3:0]            data_be_o,
    output logic [WORD_WIDTH-1:0] data_wdata_o,
    input  logic [WORD_WIDTH-1:0] data_rdata_i
);

    lsu_state_t            state_r;
    lsu_state_t            state_n;
    logic                  accept_s;
    logic                  misaligned_s;

    logic [WORD_WIDTH-1:0] addr_r;
    logic [1:0]            size_r;
    logic                  uns_r;
    logic                  we_r;
    logic [3:0]            be_r;
    logic [WORD_WIDTH-1:0] wdata_r;

    logic                  req_r;
    logic                  wb_valid_r;
    logic [WORD_WIDTH-1:0] wb_data_r;

    logic [1:0]            align_addr_s;
    logic [1:0]            align_size_s;
    logic                  align_uns_s;
    logic [3:0]            align_be_s;
    logic [WORD_WIDTH-1:0] align_wdata_s;
    logic [WORD_WIDTH-1:0] align_load_s;

    assign accept_s = (state_r == IDLE) && (load_en_i || store_en_i);

`ifdef LSU_MISALIGN_TRAP_EN
    assign misaligned_s = is_misaligned(mem_size_i, ex_data_i[1:0]);
`else
    assign misaligned_s = 1'b0;
`endif

    // In IDLE the aligner formats the incoming store; afterwards it works on
    // the latched access so the load response is extracted correctly.
    assign align_addr_s = (state_r == IDLE) ? ex_data_i[1:0]  : addr_r[1:0];
    assign align_size_s = (state_r == IDLE) ? mem_size_i      : size_r;
    assign align_uns_s  = (state_r == IDLE) ? load_unsigned_i : uns_r;

    lsu_align u_align (
        .addr_lo       (align_addr_s),
        .size          (align_size_s),
        .load_unsigned (align_uns_s),
        .store_data    (rdata2_store_i),
        .rdata         (data_rdata_i),
        .be            (align_be_s),
        .wdata         (align_wdata_s),
        .load_data     (align_load_s)
    );

    // Next-state logic of the access sequencer.
    always_comb begin
        state_n = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    if (misaligned_s) begin
                        state_n = DONE;
                    end else begin
                        state_n = REQ;
                    end
                end else begin
                    state_n = IDLE;
                end
            end
            REQ: begin
                if (data_gnt_i) begin
                    state_n = WAIT;
                end else begin
                    state_n = REQ;
                end
            end
            WAIT: begin
                if (data_rvalid_i) begin
                    state_n = DONE;
                end else begin
                    state_n = WAIT;
                end
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_n;
        end
    end

    // Capture the access attributes and formatted store data on accept.
    // A simultaneous load+store is treated as a load.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            addr_r  <= 32'h0000_0000;
            size_r  <= 2'b00;
            uns_r   <= 1'b0;
            we_r    <= 1'b0;
            be_r    <= 4'b0000;
            wdata_r <= 32'h0000_0000;
        end else if (accept_s) begin
            addr_r  <= ex_data_i;
            size_r  <= mem_size_i;
            uns_r   <= load_unsigned_i;
            we_r    <= store_en_i & ~load_en_i;
            be_r    <= align_be_s;
            wdata_r <= align_wdata_s;
        end
    end

    // Memory request and writeback result registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            req_r      <= 1'b0;
            wb_valid_r <= 1'b0;
            wb_data_r  <= 32'h0000_0000;
        end else begin
            req_r      <= (state_n == REQ);
            wb_valid_r <= (state_r == WAIT) && data_rvalid_i && !we_r;
            if ((state_r == WAIT) && data_rvalid_i && !we_r) begin
                wb_data_r <= align_load_s;
            end
        end
    end

`ifdef LSU_MISALIGN_TRAP_EN
    logic mis_r;

    // Trap pulse lands in the DONE cycle that follows a misaligned accept.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            mis_r <= 1'b0;
        end else begin
            mis_r <= accept_s && misaligned_s;
        end
    end

    assign misaligned_o = mis_r;
`else
    assign misaligned_o = 1'b0;
`endif

    assign lsu_stall_o  = accept_s || (state_r == REQ) || (state_r == WAIT);
    assign data_req_o   = req_r;
    assign data_addr_o  = {addr_r[31:2], 2'b00};
    assign data_we_o    = we_r;
    assign data_be_o    = be_r;
    assign data_wdata_o = wdata_r;
    assign wb_data_o    = wb_data_r;
    assign wb_valid_o   = wb_valid_r;

endmodule

// File: tb/tb_lsu_stage.sv
// Directed, table-driven bench for lsu_stage plus hand-written sequences
// for grant back-pressure, reset mid-access and misaligned accesses.
module tb_lsu_stage;
    import riscv_defines::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] ex_data;
    logic [31:0] rs2;
    logic        load_en;
    logic        store_en;
    logic [1:0]  mem_size;
    logic        load_uns;
    logic        stall;
    logic [31:0] wb_data;
    logic        wb_valid;
    logic        misaligned;
    logic        req;
    logic        gnt;
    logic        rvalid;
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] rdata;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    lsu_stage dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .ex_data_i       (ex_data),
        .rdata2_store_i  (rs2),
        .load_en_i       (load_en),
        .store_en_i      (store_en),
        .mem_size_i      (mem_size),
        .load_unsigned_i (load_uns),
        .lsu_stall_o     (stall),
        .wb_data_o       (wb_data),
        .wb_valid_o      (wb_valid),
        .misaligned_o    (misaligned),
        .data_req_o      (req),
        .data_gnt_i      (gnt),
        .data_rvalid_i   (rvalid),
        .data_addr_o     (addr),
        .data_we_o       (we),
        .data_be_o       (be),
        .data_wdata_o    (wdata),
        .data_rdata_i    (rdata)
    );

    typedef struct {
        logic [31:0] addr;
        logic [31:0] rs2;
        logic [31:0] rdata;
        logic        ld;
        logic        st;
        logic [1:0]  size;
        logic        uns;
        logic [3:0]  be;
        logic        we;
        logic [31:0] wdata;
        logic [31:0] wb;
        logic        wbv;
    } vec_t;

    vec_t vecs[11];

    function automatic vec_t mk(input logic [31:0] a, input logic [31:0] s, input logic [31:0] r,
                                input logic ld, input logic st, input logic [1:0] sz, input logic u,
                                input logic [3:0] b, input logic w, input logic [31:0] wd,
                                input logic [31:0] wbd, input logic wbv);
        vec_t v;
        v.addr = a; v.rs2 = s; v.rdata = r; v.ld = ld; v.st = st; v.size = sz; v.uns = u;
        v.be = b; v.we = w; v.wdata = wd; v.wb = wbd; v.wbv = wbv;
        return v;
    endfunction

    task automatic chk1(input string name, input logic act, input logic exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Full access: accept, gnt in the next cycle, rvalid in the one after.
    task automatic do_txn(input vec_t v);
        @(posedge clk); #1;
        ex_data = v.addr; rs2 = v.rs2; load_en = v.ld; store_en = v.st;
        mem_size = v.size; load_uns = v.uns;
        @(negedge clk);
        chk1("accept_stall", stall, 1'b1);
        @(posedge clk); #1;
        load_en = 1'b0; store_en = 1'b0; ex_data = 32'h0; rs2 = 32'hFFFF_FFFF; gnt = 1'b1;
        @(negedge clk);
        chk1("req_high", req, 1'b1);
        chk32("req_addr", addr, v.addr & 32'hFFFF_FFFC);
        chk32("req_be", {28'h0, be}, {28'h0, v.be});
        chk1("req_we", we, v.we);
        chk32("req_wdata", wdata, v.wdata);
        chk1("req_stall", stall, 1'b1);
        @(posedge clk); #1;
        gnt = 1'b0; rvalid = 1'b1; rdata = v.rdata;
        @(negedge clk);
        chk1("wait_req_low", req, 1'b0);
        chk1("wait_stall", stall, 1'b1);
        chk1("wait_wbvalid", wb_valid, 1'b0);
        @(posedge clk); #1;
        rvalid = 1'b0; rdata = 32'h0;
        @(negedge clk);
        chk1("done_wbvalid", wb_valid, v.wbv);
        chk32("done_wbdata", wb_data, v.wb);
        chk1("done_stall", stall, 1'b0);
        chk1("done_misaligned", misaligned, 1'b0);
        @(posedge clk); #1;
        @(negedge clk);
        chk1("idle_wbvalid", wb_valid, 1'b0);
        chk1("idle_req", req, 1'b0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; ex_data = 32'h0; rs2 = 32'h0; load_en = 1'b0; store_en = 1'b0;
        mem_size = MEM_WORD; load_uns = 1'b0; gnt = 1'b0; rvalid = 1'b0; rdata = 32'h0;

        vecs[0]  = mk(32'h100, 32'h12345678, 32'hDEADBEEF, 1'b1, 1'b0, MEM_WORD, 1'b0, 4'b1111, 1'b0, 32'h12345678, 32'hDEADBEEF, 1'b1);
        vecs[1]  = mk(32'h103, 32'h00000000, 32'h80112233, 1'b1, 1'b0, MEM_BYTE, 1'b0, 4'b1000, 1'b0, 32'h00000000, 32'hFFFFFF80, 1'b1);
        vecs[2]  = mk(32'h103, 32'h00000000, 32'h80112233, 1'b1, 1'b0, MEM_BYTE, 1'b1, 4'b1000, 1'b0, 32'h00000000, 32'h00000080, 1'b1);
        vecs[3]  = mk(32'h102, 32'h0000ABCD, 32'h55555555, 1'b0, 1'b1, MEM_HALF, 1'b0, 4'b1100, 1'b1, 32'hABCDABCD, 32'h00000080, 1'b0);
        vecs[4]  = mk(32'h102, 32'h00000000, 32'h80011234, 1'b1, 1'b0, MEM_HALF, 1'b0, 4'b1100, 1'b0, 32'h00000000, 32'hFFFF8001, 1'b1);
        vecs[5]  = mk(32'h100, 32'h00000000, 32'h8001F234, 1'b1, 1'b0, MEM_HALF, 1'b1, 4'b0011, 1'b0, 32'h00000000, 32'h0000F234, 1'b1);
        vecs[6]  = mk(32'h101, 32'h000000A5, 32'h00000000, 1'b0, 1'b1, MEM_BYTE, 1'b0, 4'b0010, 1'b1, 32'hA5A5A5A5, 32'h0000F234, 1'b0);
        vecs[7]  = mk(32'h200, 32'hCAFEF00D, 32'h00000000, 1'b0, 1'b1, MEM_WORD, 1'b0, 4'b1111, 1'b1, 32'hCAFEF00D, 32'h0000F234, 1'b0);
        vecs[8]  = mk(32'h300, 32'h00000000, 32'h11223344, 1'b1, 1'b1, MEM_WORD, 1'b0, 4'b1111, 1'b0, 32'h00000000, 32'h11223344, 1'b1);
        vecs[9]  = mk(32'h102, 32'h00000000, 32'h117F2233, 1'b1, 1'b0, MEM_BYTE, 1'b0, 4'b0100, 1'b0, 32'h00000000, 32'h0000007F, 1'b1);
        vecs[10] = mk(32'h104, 32'h00000000, 32'hA0B0C0D0, 1'b1, 1'b0, 2'b11,    1'b0, 4'b1111, 1'b0, 32'h00000000, 32'hA0B0C0D0, 1'b1);

        // Reset state.
        #2;
        chk1("rst_req", req, 1'b0);
        chk1("rst_stall", stall, 1'b0);
        chk1("rst_wbvalid", wb_valid, 1'b0);
        chk32("rst_wbdata", wb_data, 32'h0);
        chk1("rst_misaligned", misaligned, 1'b0);
        chk32("rst_addr", addr, 32'h0);
        chk32("rst_be", {28'h0, be}, 32'h0);
        chk1("rst_we", we, 1'b0);
        chk32("rst_wdata", wdata, 32'h0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 11; i++) begin
            do_txn(vecs[i]);
        end

        // Grant withheld for 5 cycles with stray rvalid during REQ;
        // enables held into DONE must not start a new access.
        @(posedge clk); #1;
        ex_data = 32'h106; rs2 = 32'h0000003C; load_en = 1'b1; mem_size = MEM_BYTE; load_uns = 1'b0;
        @(negedge clk);
        chk1("bp_accept_stall", stall, 1'b1);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            load_en = 1'b0; ex_data = 32'hFFFF_FFF0 + i; rs2 = 32'h0;
            rvalid = (i == 1 || i == 2); rdata = 32'hFFFF_FFFF;
            @(negedge clk);
            chk1("bp_req", req, 1'b1);
            chk32("bp_addr", addr, 32'h104);
            chk32("bp_be", {28'h0, be}, 32'h4);
            chk32("bp_wdata", wdata, 32'h3C3C3C3C);
            chk1("bp_stall", stall, 1'b1);
            chk1("bp_wbvalid", wb_valid, 1'b0);
        end
        @(posedge clk); #1;
        rvalid = 1'b0; gnt = 1'b1;
        @(negedge clk);
        chk1("bp_req_at_gnt", req, 1'b1);
        @(posedge clk); #1;
        gnt = 1'b0; rvalid = 1'b1; rdata = 32'h00420000;
        @(negedge clk);
        chk1("bp_wait_req", req, 1'b0);
        @(posedge clk); #1;
        rvalid = 1'b0; load_en = 1'b1; ex_data = 32'h100; mem_size = MEM_WORD;
        @(negedge clk);
        chk1("bp_done_wbvalid", wb_valid, 1'b1);
        chk32("bp_done_wbdata", wb_data, 32'h00000042);
        chk1("bp_done_stall", stall, 1'b0);
        @(posedge clk); #1;
        load_en = 1'b0;
        @(negedge clk);
        chk1("done_ignores_en_req", req, 1'b0);
        chk1("done_ignores_en_stall", stall, 1'b0);

        // Reset asserted while waiting for rvalid.
        @(posedge clk); #1;
        ex_data = 32'h100; load_en = 1'b1; mem_size = MEM_WORD;
        @(posedge clk); #1;
        load_en = 1'b0; gnt = 1'b1;
        @(posedge clk); #1;
        gnt = 1'b0;
        #1 rst = 1'b1;
        #1;
        chk1("rstwait_req", req, 1'b0);
        chk1("rstwait_stall", stall, 1'b0);
        chk32("rstwait_wbdata", wb_data, 32'h0);
        #1 rst = 1'b0;
        @(posedge clk); #1;
        rvalid = 1'b1; rdata = 32'h12345678;
        @(negedge clk);
        chk1("late_rvalid_stall", stall, 1'b0);
        chk1("late_rvalid_req", req, 1'b0);
        @(posedge clk); #1;
        rvalid = 1'b0;
        @(negedge clk);
        chk1("late_rvalid_wbvalid", wb_valid, 1'b0);
        chk32("late_rvalid_wbdata", wb_data, 32'h0);

        // Misaligned word load at 0x101.
`ifdef LSU_MISALIGN_TRAP_EN
        @(posedge clk); #1;
        ex_data = 32'h101; load_en = 1'b1; mem_size = MEM_WORD; load_uns = 1'b0;
        @(negedge clk);
        chk1("mis_accept_stall", stall, 1'b1);
        @(posedge clk); #1;
        load_en = 1'b0;
        @(negedge clk);
        chk1("mis_pulse", misaligned, 1'b1);
        chk1("mis_req", req, 1'b0);
        chk1("mis_wbvalid", wb_valid, 1'b0);
        chk32("mis_wbdata", wb_data, 32'h0);
        chk1("mis_stall", stall, 1'b0);
        @(posedge clk); #1;
        @(negedge clk);
        chk1("mis_pulse_end", misaligned, 1'b0);
        chk1("mis_req_after", req, 1'b0);
`else
        do_txn(mk(32'h101, 32'h0, 32'h01020304, 1'b1, 1'b0, MEM_WORD, 1'b0, 4'b1111, 1'b0, 32'h0, 32'h01020304, 1'b1));
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
